// File: rtl/flofifo_reader.sv
// Read-side controller for flofifo: drains a requested burst onto a ready/valid stream,
// hiding the FIFO's one-cycle read latency behind a two-entry in-order skid buffer.
module flofifo_reader #(
   parameter int WIDTH   = 32,
   parameter int LENGTH  = 32,
   parameter int BURST_W = 16
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [WIDTH-1:0]          fifo_data_i,
   input  logic                      fifo_valid_i,
   input  logic                      fifo_empty_i,
   input  logic [$clog2(LENGTH)-1:0] fifo_locs_i,
   output logic                      fifo_read_o,
   input  logic                      burst_start_i,
   input  logic [BURST_W-1:0]        burst_len_i,
   input  logic                      abort_i,
   output logic [WIDTH-1:0]          m_data_o,
   output logic                      m_valid_o,
   input  logic                      m_ready_i,
   output logic                      m_last_o,
   output logic                      busy_o,
   output logic                      done_o,
   output logic                      aborted_o,
   output logic [BURST_W-1:0]        words_sent_o
);
   localparam int LOCS_W = $clog2(LENGTH);

   typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

   state_t             state_q, state_d;
   logic [BURST_W-1:0] len_q, len_d;
   logic [BURST_W-1:0] issued_q, issued_d;
   logic [BURST_W-1:0] sent_q, sent_d;
   logic               in_flight_q, in_flight_d;
   logic [1:0]         skid_cnt_q, skid_cnt_d;
   logic [WIDTH-1:0]   skid_q [2];
   logic [WIDTH-1:0]   skid_d [2];
   logic               done_q, done_d;
   logic               aborted_q, aborted_d;

   logic               push, pop, last_beat;
   logic [1:0]         occupancy;

   assign m_valid_o    = (state_q == RUN) && (skid_cnt_q != 2'd0);
   assign m_data_o     = skid_q[0];
   assign m_last_o     = m_valid_o && (sent_q == len_q - BURST_W'(1));
   assign busy_o       = (state_q != IDLE);
   assign done_o       = done_q;
   assign aborted_o    = aborted_q;
   assign words_sent_o = sent_q;

   assign pop       = m_valid_o && m_ready_i;
   assign push      = fifo_valid_i && in_flight_q;
   assign last_beat = pop && m_last_o;

   // Counting this cycle's pop lets a steady stream issue one read per clock.
   assign occupancy = skid_cnt_q - {1'b0, pop} + {1'b0, in_flight_q};

   assign fifo_read_o = (state_q == RUN) && !abort_i && !fifo_empty_i &&
                        (fifo_locs_i > LOCS_W'(in_flight_q)) &&
                        (issued_q < len_q) && (occupancy < 2'd2);

   always_comb begin
      state_d     = state_q;
      len_d       = len_q;
      issued_d    = issued_q + BURST_W'(fifo_read_o);
      sent_d      = sent_q;
      in_flight_d = fifo_read_o || (in_flight_q && !fifo_valid_i);
      done_d      = 1'b0;
      aborted_d   = aborted_q;
      skid_d      = skid_q;
      skid_cnt_d  = skid_cnt_q + {1'b0, push} - {1'b0, pop};

      if (pop) begin
         skid_d[0] = skid_q[1];
         if (sent_q != len_q) begin
            sent_d = sent_q + BURST_W'(1);
         end
      end
      if (push) begin
         if (skid_cnt_q - {1'b0, pop} == 2'd0) begin
            skid_d[0] = fifo_data_i;
         end else begin
            skid_d[1] = fifo_data_i;
         end
      end

      unique case (state_q)
         IDLE: begin
            if (burst_start_i) begin
               len_d     = burst_len_i;
               issued_d  = '0;
               sent_d    = '0;
               aborted_d = 1'b0;
               if (burst_len_i == '0) begin
                  done_d = 1'b1;
               end else begin
                  state_d = RUN;
               end
            end
         end
         RUN: begin
            if (last_beat) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end else if (abort_i) begin
               state_d = FLUSH;
            end
         end
         FLUSH: begin
            // Only the word already requested may still land; once it has, drop everything.
            if (!in_flight_q) begin
               state_d    = IDLE;
               skid_cnt_d = 2'd0;
               aborted_d  = 1'b1;
               done_d     = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         len_q       <= '0;
         issued_q    <= '0;
         sent_q      <= '0;
         in_flight_q <= 1'b0;
         skid_cnt_q  <= 2'd0;
         skid_q[0]   <= '0;
         skid_q[1]   <= '0;
         done_q      <= 1'b0;
         aborted_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         len_q       <= len_d;
         issued_q    <= issued_d;
         sent_q      <= sent_d;
         in_flight_q <= in_flight_d;
         skid_cnt_q  <= skid_cnt_d;
         skid_q[0]   <= skid_d[0];
         skid_q[1]   <= skid_d[1];
         done_q      <= done_d;
         aborted_q   <= aborted_d;
      end
   end

endmodule
